ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
// Next-generation PS/2 keyboard receiver, fully in the clk domain with no clocking on kclk edges.
// - Samples kclk/kdata and glitch-filters both lines; frames start/8 data/odd parity/stop.
// - Decodes E0 (extended) and F0 (break) prefixes into key events on a valid/ready FIFO.
// - Keeps a parametrised raw byte history; reports parity, frame, timeout and overflow errors.
// PARAMETERS
// FILTER_LEN      8        consecutive equal samples before a filtered line may change (>=2)
// TIMEOUT_CYCLES  200000   max clk cycles between kclk falls inside a frame (2 ms @ 100 MHz)
// FIFO_DEPTH      4        event FIFO entries; power of 2, >=2
// HIST_BYTES      4        raw byte history length
// PORTS
// clk          in   1              system clock
// rst          in   1              synchronous, active-high reset
// kclk         in   1              PS/2 clock pin, asynchronous
// kdata        in   1              PS/2 data pin, asynchronous
// ev_valid     out  1              event FIFO non-empty
// ev_ready     in   1              consumer accepts head event
// ev_code      out  8              head event scancode
// ev_ext       out  1              head event carried an E0 prefix
// ev_break     out  1              head event carried an F0 prefix (key release)
// keycodeout   out  8*HIST_BYTES   raw byte history; newest byte in [7:0]
// err_parity   out  1              1-cycle pulse: parity bad, stop bit good
// err_frame    out  1              1-cycle pulse: stop bit = 0 (takes precedence over parity)
// err_timeout  out  1              1-cycle pulse: frame abandoned on timeout
// overflow     out  1              1-cycle pulse: event dropped, FIFO full
// BEHAVIOUR
// - rst has priority over all logic. It clears the FSM, counters, prefix flags, FIFO and history.
//   Filtered lines reset to 1. Every output resets to 0. A mid-frame reset discards the partial byte.
// - Filter: 2-FF sync per line. Filtered value takes a new sample only after FILTER_LEN consecutive equal samples.
// - fall = filtered kclk 1->0. Filtered kdata is sampled in the fall cycle.
// - FSM (states IDLE, DATA, PARITY, STOP; all transitions occur on fall cycles):
//   - IDLE: kdata=0 -> DATA with bitcnt=0. kdata=1 -> remain in IDLE, no error.
//   - DATA: shift bits in LSB first. The 8th bit -> PARITY.
//   - PARITY: latch the parity bit -> STOP.
//   - STOP: kdata=0 -> err_frame. Else a data^parity even count (odd parity wrong) -> err_parity.
//     Else byte_stb in the next cycle. Always -> IDLE.
// - Timeout: counter cleared on every fall and held at 0 in IDLE. Outside IDLE, reaching TIMEOUT_CYCLES-1
//   -> err_timeout, go to IDLE, discard the partial byte. A fall in the same cycle wins and clears the counter.
// - On byte_stb, every byte (prefixes included) shifts into keycodeout. No duplicate suppression.
// - Prefix decode on byte_stb:
//   - E0 sets the ext flag; F0 sets the brk flag; neither pushes an event.
//   - Any other byte pushes {code,ext,brk} and then clears both flags.
//   - Flags persist across error frames and clear only on push or rst.
// - Latency: with the FIFO empty, ev_valid rises exactly 2 cycles after the stop-bit fall cycle.
// - FIFO rules:
//   - Pop when ev_valid && ev_ready. Head outputs stay stable while ev_valid && !ev_ready.
//   - Push when full with no pop: drop the new event and pulse overflow; flags are still cleared.
//   - Push and pop in the same cycle when full: both succeed.
//   - Pointers wrap modulo FIFO_DEPTH. ev_code/ev_ext/ev_break read 0 when the FIFO is empty.
// STRUCTURE
// - ps2_pkg:
//   - FSM state enum.
//   - PS2_PFX_EXT = 8'hE0 and PS2_PFX_BRK = 8'hF0.
//   - ps2_event_t typedef {code[7:0], ext, brk}.
// - Sub-module ps2_line_filter (sync + glitch filter, parameter FILTER_LEN): one instance each for kclk and kdata.
// - FSM, timeout, prefix decode, history and FIFO are inline.
// TESTING  (clk 100 MHz; PS/2 bit period 40 us; FIFO_DEPTH=4)
// 1. Frame 0x1C, parity 0, stop 1 -> ev_valid 2 cycles after stop fall, code 1C, ext 0, brk 0;
//    keycodeout = 32'h0000001C.
// 2. Bytes E0,F0,75 -> exactly one event: code 75, ext 1, brk 1; keycodeout = 32'h00E0F075.
// 3. 0x1C with parity 1 -> single err_parity pulse, no event, history unchanged.
//    Stop=0 with bad parity -> err_frame only.
// 4. Four data bits then kclk held high -> err_timeout at TIMEOUT_CYCLES, FSM in IDLE.
//    The next frame 0x29 is decoded correctly.
// 5. ev_ready=0, five codes 15,1D,24,2D,2C -> overflow on the 5th.
//    Draining then yields 15,1D,24,2D in order. A simultaneous push/pop while full drops nothing.
// 6. 3-cycle kclk low glitch -> no bit counted. rst asserted after 5 bits -> all outputs 0;
//    the next frame 0x1C decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scancode receiver.
//   ps2_state_t  frame FSM state encoding
//   PS2_PFX_EXT  extended-key prefix byte (E0)
//   PS2_PFX_BRK  key-release prefix byte (F0)
//   ps2_event_t  one decoded key event as stored in the event FIFO
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_event_t;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: brings one asynchronous PS/2 line into the clk domain
// and suppresses glitches.
//   clk   in   system clock
//   rst   in   synchronous, active-high reset (filtered line returns to 1)
//   din   in   raw asynchronous pin
//   dout  out  synchronised, filtered line
// The filtered value only follows the synchronised line once it has seen
// FILTER_LEN consecutive samples that disagree with the current output.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      dout  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // A sample that agrees with the output restarts the run.
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver running entirely in the clk domain.
// Frames start/8 data (LSB first)/odd parity/stop, folds E0/F0 prefixes into
// key events and queues them in a valid/ready FIFO.
//   clk, rst     system clock, synchronous active-high reset
//   kclk, kdata  asynchronous PS/2 pins
//   ev_valid     FIFO non-empty
//   ev_ready     consumer accepts head event
//   ev_code      head scancode (0 when empty)
//   ev_ext       head carried E0 (0 when empty)
//   ev_break     head carried F0 (0 when empty)
//   keycodeout   raw byte history, newest byte in [7:0]
//   err_parity   1-cycle pulse: parity wrong, stop bit good
//   err_frame    1-cycle pulse: stop bit low
//   err_timeout  1-cycle pulse: frame abandoned, kclk stalled
//   overflow     1-cycle pulse: event dropped because FIFO full
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned HIST_BYTES     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    kclk,
  input  logic                    kdata,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [7:0]              ev_code,
  output logic                    ev_ext,
  output logic                    ev_break,
  output logic [8*HIST_BYTES-1:0] keycodeout,
  output logic                    err_parity,
  output logic                    err_frame,
  output logic                    err_timeout,
  output logic                    overflow
);

  localparam int unsigned TCW  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;

  // ---------------------------------------------------------------- inputs
  logic kclk_f;
  logic kdata_f;
  logic kclk_prev;
  logic fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_kclk (
    .clk  (clk),
    .rst  (rst),
    .din  (kclk),
    .dout (kclk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_kdata (
    .clk  (clk),
    .rst  (rst),
    .din  (kdata),
    .dout (kdata_f)
  );

  always_ff @(posedge clk) begin
    if (rst) kclk_prev <= 1'b1;
    else     kclk_prev <= kclk_f;
  end

  assign fall = kclk_prev & ~kclk_f;

  // ------------------------------------------------- frame FSM and timeout
  ps2_state_t     state;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic           par;
  logic [TCW-1:0] tcnt;
  logic           byte_stb;
  logic [7:0]     byte_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tcnt        <= '0;
      byte_stb    <= 1'b0;
      byte_q      <= '0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      byte_stb    <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      // A fall always restarts the stall counter, even on the cycle the
      // counter would otherwise expire.
      if (fall) begin
        tcnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!kdata_f) begin
              state  <= ST_DATA;
              bitcnt <= '0;
            end
          end
          ST_DATA: begin
            shreg  <= {kdata_f, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= kdata_f;
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!kdata_f) begin
              err_frame <= 1'b1;
            end else if (!(^{shreg, par})) begin
              err_parity <= 1'b1;
            end else begin
              byte_stb <= 1'b1;
              byte_q   <= shreg;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state == ST_IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
        err_timeout <= 1'b1;
        state       <= ST_IDLE;
        tcnt        <= '0;
      end else begin
        tcnt <= tcnt + TCW'(1);
      end
    end
  end

  // ------------------------------------- prefix decode, history, event FIFO
  logic                      ext_flag;
  logic                      brk_flag;
  logic                      is_ext;
  logic                      is_brk;
  logic                      push_ev;
  logic                      pop_ev;
  logic                      full;
  logic                      do_push;
  logic [8*HIST_BYTES+7:0]   hist_sh;
  ps2_event_t                new_ev;
  ps2_event_t                head;
  ps2_event_t                fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]             wptr;
  logic [PW-1:0]             rptr;
  logic [CNTW-1:0]           count;

  always_comb begin
    is_ext      = (byte_q == PS2_PFX_EXT);
    is_brk      = (byte_q == PS2_PFX_BRK);
    push_ev     = byte_stb && !is_ext && !is_brk;
    pop_ev      = ev_valid && ev_ready;
    full        = (count == CNTW'(FIFO_DEPTH));
    // When full, a simultaneous pop frees the slot this push needs.
    do_push     = push_ev && (!full || pop_ev);
    hist_sh     = {keycodeout, byte_q};
    new_ev      = '0;
    new_ev.code = byte_q;
    new_ev.ext  = ext_flag;
    new_ev.brk  = brk_flag;
    head        = fifo_mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      keycodeout <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      overflow <= 1'b0;
      if (byte_stb) begin
        keycodeout <= hist_sh[8*HIST_BYTES-1:0];
        if (is_ext) begin
          ext_flag <= 1'b1;
        end else if (is_brk) begin
          brk_flag <= 1'b1;
        end else begin
          // Flags clear even when the event itself is dropped.
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
      if (do_push) begin
        fifo_mem[wptr] <= new_ev;
        wptr           <= wptr + PW'(1);
      end
      if (push_ev && !do_push) overflow <= 1'b1;
      if (pop_ev) rptr <= rptr + PW'(1);
      case ({do_push, pop_ev})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  assign ev_valid = (count != '0);
  assign ev_code  = ev_valid ? head.code : '0;
  assign ev_ext   = ev_valid ? head.ext  : 1'b0;
  assign ev_break = ev_valid ? head.brk  : 1'b0;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Testbench for ps2_scancode_rx. PS/2 bit period and the stall timeout are
// scaled down (40-cycle bit, 300-cycle timeout) so the run stays short;
// the relative timing of kclk/kdata matches a real keyboard.
module tb_ps2_scancode_rx;

  localparam int unsigned FL = 8;
  localparam int unsigned TO = 300;
  localparam int unsigned FD = 4;
  localparam int unsigned HB = 4;
  localparam int unsigned H  = 20;   // half PS/2 bit period in clk cycles

  logic          clk = 1'b0;
  logic          rst;
  logic          kclk;
  logic          kdata;
  logic          ev_valid;
  logic          ev_ready;
  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_break;
  logic [8*HB-1:0] keycodeout;
  logic          err_parity;
  logic          err_frame;
  logic          err_timeout;
  logic          overflow;

  ps2_scancode_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (FD),
    .HIST_BYTES     (HB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .kclk        (kclk),
    .kdata       (kdata),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_break    (ev_break),
    .keycodeout  (keycodeout),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_timeout (err_timeout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_par   = 0;
  int unsigned n_frm   = 0;
  int unsigned n_to    = 0;
  int unsigned n_ovf   = 0;
  int unsigned to_cyc  = 0;
  int unsigned rise_cyc = 0;
  int unsigned stop_cyc = 0;
  logic        valid_d = 1'b0;
  logic [9:0]  sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: error pulse counters and event scoreboard.
  always @(negedge clk) begin
    logic [9:0] e;
    if (err_parity)  n_par++;
    if (err_frame)   n_frm++;
    if (overflow)    n_ovf++;
    if (err_timeout) begin
      n_to++;
      to_cyc = cyc;
    end
    if (ev_valid && !valid_d) rise_cyc = cyc;
    valid_d = ev_valid;
    if (ev_valid && ev_ready) begin
      if (sb.size() == 0) begin
        chk("ev_unexpected", {22'd0, ev_code, ev_ext, ev_break}, 32'hFFFFFFFF);
      end else begin
        e = sb.pop_front();
        chk("ev", {22'd0, ev_code, ev_ext, ev_break}, {22'd0, e});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    kclk  = 1'b1;
    kdata = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(FL + 4);
  endtask

  task automatic bit_fall(input logic b);
    kdata = b;
    wait_cyc(H);
    kclk     = 1'b0;
    stop_cyc = cyc;
  endtask

  task automatic bit_rise();
    wait_cyc(H);
    kclk = 1'b1;
  endtask

  // Drives everything up to and including the stop-bit kclk fall.
  task automatic send_head(input logic [7:0] d, input logic p, input logic stop);
    bit_fall(1'b0);
    bit_rise();
    for (int i = 0; i < 8; i++) begin
      bit_fall(d[i]);
      bit_rise();
    end
    bit_fall(p);
    bit_rise();
    bit_fall(stop);
  endtask

  task automatic send_tail();
    bit_rise();
    kdata = 1'b1;
    wait_cyc(2 * H);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d, ~^d, 1'b1);
    send_tail();
  endtask

  task automatic send_partial(input logic [3:0] d);
    bit_fall(1'b0);
    bit_rise();
    for (int i = 0; i < 4; i++) begin
      bit_fall(d[i]);
      bit_rise();
    end
    kdata = 1'b1;
  endtask

  initial begin
    int unsigned p0, f0, t0, o0;
    ev_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // reset state
    chk("rst_valid", {31'd0, ev_valid}, 32'd0);
    chk("rst_code", {24'd0, ev_code}, 32'd0);
    chk("rst_hist", keycodeout, 32'd0);
    chk("rst_errs", {28'd0, err_parity, err_frame, err_timeout, overflow}, 32'd0);

    // 1: single make code, latency of 2 cycles after the stop fall cycle
    sb.push_back({8'h1C, 1'b0, 1'b0});
    send_head(8'h1C, 1'b0, 1'b1);
    send_tail();
    chk("t1_latency", rise_cyc - stop_cyc, FL + 4);
    chk("t1_valid_held", {31'd0, ev_valid}, 32'd1);
    chk("t1_hist", keycodeout, 32'h0000001C);
    ev_ready = 1'b1;
    wait_cyc(3);
    chk("t1_drained", sb.size(), 32'd0);

    // 2: E0 F0 75 -> one extended release event
    do_reset();
    sb.push_back({8'h75, 1'b1, 1'b1});
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    chk("t2_hist", keycodeout, 32'h00E0F075);
    chk("t2_events", sb.size(), 32'd0);

    // 3: bad parity, then stop=0 with bad parity
    p0 = n_par;
    f0 = n_frm;
    send_head(8'h1C, 1'b1, 1'b1);
    send_tail();
    chk("t3_par_cnt", n_par, p0 + 1);
    chk("t3_frm_cnt0", n_frm, f0);
    chk("t3_hist", keycodeout, 32'h00E0F075);
    chk("t3_no_ev", {31'd0, ev_valid}, 32'd0);
    send_head(8'h1C, 1'b1, 1'b0);
    send_tail();
    chk("t3_frm_cnt", n_frm, f0 + 1);
    chk("t3_par_cnt2", n_par, p0 + 1);

    // 4: stall mid-frame -> timeout, then a clean frame
    t0 = n_to;
    send_partial(4'b1010);
    for (int i = 0; i < int'(TO) + 100 && n_to == t0; i++) wait_cyc(1);
    chk("t4_to_cnt", n_to, t0 + 1);
    chk("t4_to_time", to_cyc - stop_cyc, FL + 3 + TO);
    wait_cyc(H);
    sb.push_back({8'h29, 1'b0, 1'b0});
    send_frame(8'h29);
    chk("t4_hist", keycodeout, 32'hE0F07529);
    chk("t4_events", sb.size(), 32'd0);

    // 5: fill FIFO, overflow on the fifth, push+pop while full
    ev_ready = 1'b0;
    o0 = n_ovf;
    sb.push_back({8'h15, 2'b00});
    send_frame(8'h15);
    sb.push_back({8'h1D, 2'b00});
    send_frame(8'h1D);
    sb.push_back({8'h24, 2'b00});
    send_frame(8'h24);
    sb.push_back({8'h2D, 2'b00});
    send_frame(8'h2D);
    chk("t5_no_ovf_yet", n_ovf, o0);
    send_frame(8'h2C);
    chk("t5_ovf", n_ovf, o0 + 1);
    chk("t5_head", {22'd0, ev_code, ev_ext, ev_break}, {22'd0, 8'h15, 2'b00});
    sb.push_back({8'h1B, 2'b00});
    send_head(8'h1B, ~^8'h1B, 1'b1);
    wait_cyc(FL + 3);
    ev_ready = 1'b1;              // pop lands on the same edge as the push
    wait_cyc(1);
    ev_ready = 1'b0;
    send_tail();
    chk("t5_pp_no_ovf", n_ovf, o0 + 1);
    chk("t5_pp_head", {24'd0, ev_code}, 32'h1D);
    ev_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) wait_cyc(1);
    wait_cyc(2);
    chk("t5_drained", sb.size(), 32'd0);
    chk("t5_empty_valid", {31'd0, ev_valid}, 32'd0);
    chk("t5_empty_code", {22'd0, ev_code, ev_ext, ev_break}, 32'd0);

    // 6a: 3-cycle kclk glitch with kdata low must not start a frame
    p0 = n_par;
    f0 = n_frm;
    kdata = 1'b0;
    wait_cyc(H);
    kclk = 1'b0;
    wait_cyc(3);
    kclk = 1'b1;
    wait_cyc(H);
    kdata = 1'b1;
    wait_cyc(H);
    sb.push_back({8'h34, 2'b00});
    send_frame(8'h34);
    chk("t6_glitch_ev", sb.size(), 32'd0);
    chk("t6_glitch_err", n_par + n_frm, p0 + f0);
    chk("t6_glitch_hist", keycodeout[7:0], 32'h34);

    // 6b: reset after five bits of a frame with an event queued
    ev_ready = 1'b0;
    sb.push_back({8'h1C, 2'b00});
    send_frame(8'h1C);
    send_partial(4'b0110);
    rst = 1'b1;
    wait_cyc(3);
    sb.delete();
    chk("t6_rst_valid", {31'd0, ev_valid}, 32'd0);
    chk("t6_rst_head", {22'd0, ev_code, ev_ext, ev_break}, 32'd0);
    chk("t6_rst_hist", keycodeout, 32'd0);
    chk("t6_rst_errs", {28'd0, err_parity, err_frame, err_timeout, overflow}, 32'd0);
    rst = 1'b0;
    wait_cyc(FL + 4);
    ev_ready = 1'b1;
    sb.push_back({8'h1C, 2'b00});
    send_frame(8'h1C);
    chk("t6_after_hist", keycodeout, 32'h0000001C);
    chk("t6_after_ev", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
